tone_decoder: RTL
=================

Name: tone_decoder

Overview:
- Receive-side counterpart to the music processor's speaker output: takes a square-wave tone on an input pin and identifies which of the eight scale notes (C4..C5) is being played.
- Uses gated frequency counting. Rising edges are counted over a fixed window timed from the shared ticks_per_milli prescale value, the count is converted to Hz and classified, and the result is shown on the 7-segment LED output.
- A two-window agreement filter suppresses glitches.

Parameters:
- GATE_MS, 250, counting window in ms. Legal values: 100, 125, 200, 250, 500, 1000 (must divide 1000).
- CNT_W, 16, edge-counter width. Counter saturates at all-ones.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ticks_per_milli  input  16  clk cycles per ms, quasi-static; 0 is treated as 1
- tone_in  input  1  asynchronous square-wave tone
- led  output  8  segments; bit0=a..bit6=g, bit7=dp
- note  output  3  note index 0=C4, 1=D4, 2=E4, 3=F4, 4=G4, 5=A4, 6=B4, 7=C5
- note_valid  output  1  high while a note is locked
- freq_hz  output  16  last window's estimate, count*(1000/GATE_MS), saturating
- window_done  output  1  one-cycle pulse when the outputs update

Behaviour:
- Reset is asynchronous and active-low: clk with rst_n. While rst_n=0:
  - all counters and synchronizers clear;
  - note=0, note_valid=0, freq_hz=0, window_done=0;
  - led=8'h40 (dash);
  - candidate register is empty.
- Reset asserted mid-window discards the partial count. The first window after release starts a full GATE_MS.
- Input path: tone_in passes through a 2-flop synchronizer, then a rising-edge detect on the synchronized value. An edge is counted 3 cycles after the pin edge.
- ms prescaler:
  - counts 0..max(ticks_per_milli,1)-1 and pulses ms_tick on wrap;
  - ms counter counts 0..GATE_MS-1 on ms_tick; gate_end pulses when it wraps.
- Edge counter:
  - increments on each detected edge, saturating at 2^CNT_W-1;
  - on gate_end the count (including any edge in that same cycle) is latched into win_cnt and the counter restarts at 0.
- Classification, in the cycle after gate_end, on f = win_cnt*(1000/GATE_MS), saturated to 16 bits:
  - f < 247 → none
  - 247..277 → 0
  - 278..311 → 1
  - 312..339 → 2
  - 340..370 → 3
  - 371..415 → 4
  - 416..466 → 5
  - 467..508 → 6
  - 509..550 → 7
  - f > 550 → none
- Lock FSM, evaluated once per window:
  - States: SILENT, CANDIDATE(c), LOCKED(n).
  - class = none → SILENT from any state; note_valid=0; note holds its last value.
  - SILENT with class=k → CANDIDATE(k); note_valid stays 0.
  - CANDIDATE(c) with class=c → LOCKED(c); note=c, note_valid=1.
  - CANDIDATE(c) with class=k≠c → CANDIDATE(k).
  - LOCKED(n) with class=n → stay; outputs unchanged.
  - LOCKED(n) with class=k≠n → CANDIDATE(k); note_valid=0.
- Output timing:
  - freq_hz, note, note_valid and led are registered and update together 2 cycles after gate_end.
  - window_done pulses in that same cycle.
  - Minimum latency from a stable tone to note_valid is 2 full windows.
- led encoding:
  - note_valid=0 → 8'h40 (dash);
  - note_valid=1 → C4 39, D4 5E, E4 79, F4 71, G4 3D, A4 77, B4 7C, C5 B9 (C with dp).
- A change of ticks_per_milli takes effect at the next prescaler wrap. A window already in progress is not restarted.
- Constant-high or constant-low tone_in gives count 0 → none → SILENT.

Test Plan:
- Reset, then release with tone_in=0 and ticks_per_milli=10: led=8'h40 and note_valid=0 throughout. window_done pulses once every 2500 clk; freq_hz=0.
- 440 Hz (110 edges per window) for 3 windows: after window 1 note_valid=0 and freq_hz=440. After window 2 note=5, note_valid=1, led=8'h77.
- Boundary counts per window:
  - 61 edges → 244 Hz, none;
  - 62 → 248, C4;
  - 137 → 548, C5;
  - 138 → 552, none.
  - Applying 131 edges (524 Hz) twice → note=7, led=8'hB9.
- Lock at 392 Hz (note 4), then switch to 330 Hz:
  - the next window gives note_valid=0 and led=8'h40;
  - the following window gives note=2, led=8'h79.
  - Then one window with 0 edges → SILENT, and note stays 2 with note_valid=0.
- Edge on the exact gate_end cycle: it is counted in the closing window. Also drive 70000 edges with CNT_W=16: freq_hz saturates at 65535 and class=none.
- Assert rst_n low mid-window while LOCKED at A4: outputs return to their reset values immediately (asynchronously). After release, two full windows are required before note_valid=1.

Source files
------------

// File: rtl/tone_decoder.sv
// Gated-frequency tone decoder: counts tone edges per GATE_MS window and locks onto C4..C5.
// Latency: an edge is counted 3 clk after the pin edge; outputs update 2 clk after a window closes.
// Backpressure: none; results are overwritten every window and window_done marks each update.
module tone_decoder #(
    parameter int GATE_MS = 250,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ticks_per_milli,
    input  logic        tone_in,
    output logic [7:0]  led,
    output logic [2:0]  note,
    output logic        note_valid,
    output logic [15:0] freq_hz,
    output logic        window_done
);
    localparam int MULT   = 1000 / GATE_MS;
    localparam int MS_W   = $clog2(GATE_MS);
    localparam int PROD_W = (CNT_W + 4 > 17) ? CNT_W + 4 : 17;
    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(GATE_MS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [7:0]       LED_DASH = 8'h40;

    typedef enum logic [1:0] {ST_SILENT, ST_CAND, ST_LOCKED} state_t;

    // Returns {hit, note index}; hit=0 means the frequency is outside every note band.
    function automatic logic [3:0] classify(input logic [15:0] f);
        logic [3:0] r;
        r = 4'b0000;
        if      (f < 16'd247)  r = 4'b0000;
        else if (f <= 16'd277) r = {1'b1, 3'd0};
        else if (f <= 16'd311) r = {1'b1, 3'd1};
        else if (f <= 16'd339) r = {1'b1, 3'd2};
        else if (f <= 16'd370) r = {1'b1, 3'd3};
        else if (f <= 16'd415) r = {1'b1, 3'd4};
        else if (f <= 16'd466) r = {1'b1, 3'd5};
        else if (f <= 16'd508) r = {1'b1, 3'd6};
        else if (f <= 16'd550) r = {1'b1, 3'd7};
        return r;
    endfunction

    function automatic logic [7:0] seg_of(input logic [2:0] n);
        logic [7:0] s;
        s = LED_DASH;
        case (n)
            3'd0: s = 8'h39;
            3'd1: s = 8'h5E;
            3'd2: s = 8'h79;
            3'd3: s = 8'h71;
            3'd4: s = 8'h3D;
            3'd5: s = 8'h77;
            3'd6: s = 8'h7C;
            3'd7: s = 8'hB9;
            default: s = LED_DASH;
        endcase
        return s;
    endfunction

    // [1:0] is the synchronizer, [2] holds the previous synchronized level for edge detect.
    logic [2:0] tone_sync;
    logic       edge_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tone_sync <= '0;
        else        tone_sync <= {tone_sync[1:0], tone_in};
    end

    assign edge_det = tone_sync[1] & ~tone_sync[2];

    logic [15:0]     tpm_eff;
    logic [15:0]     presc;
    logic            ms_tick;
    logic [MS_W-1:0] ms_cnt;
    logic            gate_end;

    assign tpm_eff  = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
    // >= rather than == so a shrinking ticks_per_milli wraps immediately instead of running to 65535.
    assign ms_tick  = (presc >= tpm_eff - 16'd1);
    assign gate_end = ms_tick && (ms_cnt == MS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else begin
            presc <= ms_tick ? 16'd0 : presc + 16'd1;
            if (ms_tick) ms_cnt <= gate_end ? '0 : ms_cnt + 1'b1;
        end
    end

    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] win_cnt;
    logic             win_vld;

    assign cnt_inc = (edge_det && (edge_cnt != CNT_MAX)) ? edge_cnt + 1'b1 : edge_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            win_cnt  <= '0;
            win_vld  <= 1'b0;
        end else begin
            win_vld <= gate_end;
            if (gate_end) begin
                win_cnt  <= cnt_inc;
                edge_cnt <= '0;
            end else begin
                edge_cnt <= cnt_inc;
            end
        end
    end

    logic [PROD_W-1:0] prod;
    logic [15:0]       freq_calc;
    logic [3:0]        cls;
    logic              cls_hit;
    logic [2:0]        cls_idx;

    assign prod      = PROD_W'(win_cnt) * PROD_W'(MULT);
    assign freq_calc = (|prod[PROD_W-1:16]) ? 16'hFFFF : prod[15:0];
    assign cls       = classify(freq_calc);
    assign cls_hit   = cls[3];
    assign cls_idx   = cls[2:0];

    state_t      state, state_nxt;
    logic [2:0]  cand, cand_nxt;
    logic [2:0]  note_nxt;
    logic        valid_nxt;
    logic [15:0] freq_nxt;
    logic [7:0]  led_nxt;
    logic        done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_SILENT;
            cand        <= '0;
            note        <= '0;
            note_valid  <= 1'b0;
            freq_hz     <= '0;
            led         <= LED_DASH;
            window_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            cand        <= cand_nxt;
            note        <= note_nxt;
            note_valid  <= valid_nxt;
            freq_hz     <= freq_nxt;
            led         <= led_nxt;
            window_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        note_nxt  = note;
        valid_nxt = note_valid;
        freq_nxt  = freq_hz;
        led_nxt   = led;
        done_nxt  = 1'b0;
        if (win_vld) begin
            done_nxt = 1'b1;
            freq_nxt = freq_calc;
            if (!cls_hit) begin
                state_nxt = ST_SILENT;
                valid_nxt = 1'b0;
            end else begin
                case (state)
                    ST_SILENT: begin
                        state_nxt = ST_CAND;
                        cand_nxt  = cls_idx;
                        valid_nxt = 1'b0;
                    end
                    ST_CAND: begin
                        if (cls_idx == cand) begin
                            state_nxt = ST_LOCKED;
                            note_nxt  = cls_idx;
                            valid_nxt = 1'b1;
                        end else begin
                            cand_nxt = cls_idx;
                        end
                    end
                    ST_LOCKED: begin
                        if (cls_idx != note) begin
                            state_nxt = ST_CAND;
                            cand_nxt  = cls_idx;
                            valid_nxt = 1'b0;
                        end
                    end
                    default: begin
                        state_nxt = ST_SILENT;
                        valid_nxt = 1'b0;
                    end
                endcase
            end
            led_nxt = valid_nxt ? seg_of(note_nxt) : LED_DASH;
        end
    end

endmodule
